logic_unit_arbiter: RTL and testbench

//  Shares one registered WIDTH-bit bitwise logic unit between NUM_REQ requesters.
//  - Grants one requester at a time, round-robin.
//  - Latches that requester's operands and computes y = a & b.
//  - Returns the result, tagged with the requester ID, on a single valid/ready response channel.
//  - Sits between the test/stimulus masters and the shared logic datapath in the comms-interfaces benches.

---
 rtl/logic_unit_arb_pkg.sv | 30 +++
 rtl/logic_unit_arbiter_rr_picker.sv | 33 +++
 rtl/logic_unit_arbiter.sv | 130 +++++++++++++
 tb/tb_logic_unit_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_arb_pkg.sv
// Shared types and the bitwise operation helper for logic_unit_arbiter.
package logic_unit_arb_pkg;

    // Widest operand the helper handles; callers truncate the result to their WIDTH.
    localparam int unsigned MAX_W = 64;
    localparam int unsigned OP_W  = 2;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_NAND} op_t;

    // Bitwise result of one operation; NAND is complemented across all MAX_W bits
    // and the caller keeps only its low WIDTH bits.
    function automatic logic [MAX_W-1:0] logic_op(
        input op_t              op,
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b
    );
        logic [MAX_W-1:0] y;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            default: y = a & b;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/logic_unit_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo NUM_REQ.
module rr_picker
    import logic_unit_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    winner
);

    logic        found;
    int unsigned idx;

    // Scan NUM_REQ positions starting at ptr; the first hit wins.
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                winner      = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one registered bitwise logic unit between NUM_REQ requesters,
// round-robin, returning the result tagged with the requester index.
// Optional feature macro: LOGIC_UNIT_ARB_MULTIOP_EN (AND/OR/XOR/NAND via req_op;
// otherwise always AND and req_op is ignored). WIDTH may be at most 64.
module logic_unit_arbiter
    import logic_unit_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned WIDTH   = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*2-1:0]     req_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_y,
    output logic [ID_W-1:0]          rsp_id
);

    state_t             state, state_d;
    logic [ID_W-1:0]    rr_ptr, rr_ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               rsp_valid_d;
    logic [WIDTH-1:0]   rsp_y_d;
    logic [ID_W-1:0]    rsp_id_d;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    winner;
    logic               any_req;
    op_t                op_sel;

    assign any_req = |req_valid;

`ifdef LOGIC_UNIT_ARB_MULTIOP_EN
    op_t op_q, op_d;
    assign op_sel = op_q;
`else
    // Op codes are not used in the AND-only build.
    logic unused_req_op;
    assign unused_req_op = ^req_op;
    assign op_sel        = OP_AND;
`endif

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .grant  (grant),
        .winner (winner)
    );

    // Grant only while idle and out of reset.
    assign req_ready = (rst_n && (state == IDLE)) ? grant : '0;

    // Next-state and next-register values.
    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid;
        rsp_y_d     = rsp_y;
        rsp_id_d    = rsp_id;
`ifdef LOGIC_UNIT_ARB_MULTIOP_EN
        op_d        = op_q;
`endif
        case (state)
            IDLE: begin
                if (any_req) begin
                    a_d      = req_a[32'(winner)*WIDTH +: WIDTH];
                    b_d      = req_b[32'(winner)*WIDTH +: WIDTH];
`ifdef LOGIC_UNIT_ARB_MULTIOP_EN
                    op_d     = op_t'(req_op[32'(winner)*OP_W +: OP_W]);
`endif
                    id_d     = winner;
                    rr_ptr_d = (32'(winner) == NUM_REQ - 1) ? '0 : winner + ID_W'(1);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_y_d     = WIDTH'(logic_op(op_sel, MAX_W'(a_q), MAX_W'(b_q)));
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_id    <= '0;
`ifdef LOGIC_UNIT_ARB_MULTIOP_EN
            op_q      <= OP_AND;
`endif
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            id_q      <= id_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rsp_valid <= rsp_valid_d;
            rsp_y     <= rsp_y_d;
            rsp_id    <= rsp_id_d;
`ifdef LOGIC_UNIT_ARB_MULTIOP_EN
            op_q      <= op_d;
`endif
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter with a transaction-level reference model.
module tb_logic_unit_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned W  = 4;
    localparam int unsigned IW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*W-1:0]   req_a = '0;
    logic [NR*W-1:0]   req_b = '0;
    logic [NR*2-1:0]   req_op = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [W-1:0]      rsp_y;
    logic [IW-1:0]     rsp_id;

    // Requester-side model: operands per requester, pending mask, pointer.
    logic [W-1:0]  ma [NR];
    logic [W-1:0]  mb [NR];
    logic [1:0]    mo [NR];
    logic [NR-1:0] pend = '0;
    int            m_ptr = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id)
    );

    function automatic logic [W-1:0] ref_f(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef LOGIC_UNIT_ARB_MULTIOP_EN
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a & b);
        endcase
`else
        return a & b;
`endif
    endfunction

    // First pending requester searching from ptr upward, wrapping; -1 if none.
    function automatic int pick(input logic [NR-1:0] p, input int ptr);
        for (int k = 0; k < NR; k++)
            if (p[(ptr + k) % NR]) return (ptr + k) % NR;
        return -1;
    endfunction

    task automatic drive_inputs();
        req_valid = pend;
        for (int i = 0; i < NR; i++) begin
            req_a[i*W +: W] = ma[i];
            req_b[i*W +: W] = mb[i];
            req_op[i*2 +: 2] = mo[i];
        end
    endtask

    // One full transaction; entered and left just after a falling edge with the DUT idle.
    task automatic do_txn(input int stall);
        int            w;
        logic [W-1:0]  ey;
        logic [NR-1:0] er;
        w = pick(pend, m_ptr);
        drive_inputs();
        #1;
        er = '0;
        er[w] = 1'b1;
        n_cmp++;
        if (req_ready !== er) begin
            n_bad++;
            $display("FAIL grant: req_ready=%b expected %b", req_ready, er);
        end
        ey = ref_f(mo[w], ma[w], mb[w]);
        @(posedge clk);
        @(negedge clk);
        // Granted requester moves on to fresh operands; the DUT must use its latched copy.
        pend[w] = 1'b0;
        ma[w] = W'($urandom);
        mb[w] = W'($urandom);
        mo[w] = 2'($urandom);
        drive_inputs();
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== '0) begin
            n_bad++;
            $display("FAIL exec_cycle: rsp_valid=%b req_ready=%b expected 0 and 0000", rsp_valid, req_ready);
        end
        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_y !== ey || rsp_id !== IW'(w) || req_ready !== '0) begin
                n_bad++;
                $display("FAIL resp(stall %0d): valid=%b y=%h id=%0d ready=%b expected 1 %h %0d 0000",
                         s, rsp_valid, rsp_y, rsp_id, req_ready, 1'b1, ey, w);
            end
            pend = pend | NR'($urandom_range(0, (1 << NR) - 1));
            drive_inputs();
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL handshake_clear: rsp_valid=%b expected 0", rsp_valid);
        end
        m_ptr = (w + 1) % NR;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NR; i++) begin
            ma[i] = W'($urandom); mb[i] = W'($urandom); mo[i] = 2'($urandom);
        end
        rst_n = 1'b0;
        pend = '1;
        rsp_ready = 1'b1;
        drive_inputs();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_y !== '0 || rsp_id !== '0) begin
            n_bad++;
            $display("FAIL reset_state: ready=%b valid=%b y=%h id=%0d expected 0000 0 0 0",
                     req_ready, rsp_valid, rsp_y, rsp_id);
        end
        rst_n = 1'b1;
        rsp_ready = 1'b0;
        pend = '0;
        drive_inputs();
        m_ptr = 0;
        @(negedge clk);
    endtask

    task automatic test_single();
        pend = 4'b0001;
        ma[0] = 4'b0100; mb[0] = 4'b1100; mo[0] = 2'b00;
        do_txn(0);
    endtask

    task automatic test_idle(input int n);
        pend = '0;
        drive_inputs();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== '0 || rsp_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL idle: ready=%b valid=%b expected 0000 0", req_ready, rsp_valid);
            end
        end
    endtask

    task automatic test_fairness();
        for (int k = 0; k < 5; k++) begin
            pend = '1;
            do_txn(0);
        end
    endtask

    task automatic test_back_to_back();
        pend = 4'b0010;
        do_txn(5);
        pend = '1;
        do_txn(2);
    endtask

    task automatic test_ptr_skip();
        pend = 4'b0010;
        do_txn(0);
        pend = 4'b0010;
        do_txn(0);
        pend = 4'b1011;
        do_txn(0);
    endtask

    task automatic test_reset_mid();
        // Reset while the operation is executing.
        pend = 4'b0100;
        drive_inputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        pend = '1;
        drive_inputs();
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== '0) begin
            n_bad++;
            $display("FAIL reset_exec: valid=%b ready=%b expected 0 0000", rsp_valid, req_ready);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== '0) begin
            n_bad++;
            $display("FAIL reset_hold: valid=%b ready=%b expected 0 0000", rsp_valid, req_ready);
        end
        rst_n = 1'b1;
        m_ptr = 0;
        do_txn(0);
        // Reset while the response is waiting.
        test_idle(1);
        pend = 4'b1000;
        drive_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_y !== '0 || rsp_id !== '0) begin
            n_bad++;
            $display("FAIL reset_resp: valid=%b y=%h id=%0d expected 0 0 0", rsp_valid, rsp_y, rsp_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        pend = '0;
        test_idle(2);
    endtask

    task automatic test_ops();
        for (int op = 0; op < 4; op++) begin
            pend = 4'b0001;
            ma[0] = 4'b1010; mb[0] = 4'b0110; mo[0] = 2'(op);
            do_txn(0);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    ma[i] = W'($urandom); mb[i] = W'($urandom); mo[i] = 2'($urandom);
                end else if (pend[i] && $urandom_range(0, 7) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            if (pend == '0) test_idle(1);
            else do_txn(int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_idle(3);
        test_fairness();
        test_back_to_back();
        test_ptr_skip();
        test_reset_mid();
        test_ops();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
